// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer width and
// Gray/binary conversion helpers used by both pointer domains.
package fifo_pkg;

  localparam int unsigned ADDRESS_WIDTH = 4;
  localparam int unsigned PTR_W         = ADDRESS_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      b[j] = ^(g >> j);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write-side full and read-side empty blocks.
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int unsigned W = fifo_pkg::PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int unsigned j = 0; j < W; j++) begin
      bin[j] = ^(gray >> j);
    end
  end

endmodule

// File: rtl/wr_ptr_full.sv
// Write-domain pointer, full/almost-full and level generator for the async FIFO.
// Optional sticky overflow flag enabled by defining WR_PTR_OVERFLOW_ERR_EN.
module wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = fifo_pkg::ADDRESS_WIDTH,
  parameter int unsigned AF_THRESH     = 14
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     W_INC,
  input  logic [ADDRESS_WIDTH:0]   Wq2_Rptr,
  output logic [ADDRESS_WIDTH:0]   W_ptr,
  output logic [ADDRESS_WIDTH-1:0] W_addr,
  output logic                     W_en,
  output logic                     W_full,
  output logic                     W_almost_full,
  output logic [ADDRESS_WIDTH:0]   W_level,
  output logic                     W_ovf
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          af_next;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray (Wq2_Rptr),
    .bin  (rbin)
  );

  // Gated by RST so the memory never writes on a reset edge, where the
  // pointer update is discarded anyway.
  assign W_en   = W_INC & ~W_full & ~RST;
  assign W_addr = wbin[AW-1:0];

  always_comb begin
    wbin_next  = wbin + PW'(W_en);
    wgray_next = PW'(bin2gray(32'(wbin_next)));
    level_next = wbin_next - rbin;
    full_next  = (wgray_next == {~Wq2_Rptr[AW:AW-1], Wq2_Rptr[AW-2:0]});
    af_next    = (level_next >= PW'(AF_THRESH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin          <= '0;
      W_ptr         <= '0;
      W_full        <= 1'b0;
      W_almost_full <= 1'b0;
      W_level       <= '0;
    end else begin
      wbin          <= wbin_next;
      W_ptr         <= wgray_next;
      W_full        <= full_next;
      W_almost_full <= af_next;
      W_level       <= level_next;
    end
  end

`ifdef WR_PTR_OVERFLOW_ERR_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      W_ovf <= 1'b0;
    end else if (W_INC && W_full) begin
      W_ovf <= 1'b1;
    end
  end
`else
  assign W_ovf = 1'b0;
`endif

endmodule
